// File: rtl/centroid_track_smoother.sv
// centroid_track_smoother
// Keeps a stable player index for the 4 k-means centroids across frames
// (greedy nearest-first Manhattan matching) and smooths each tracked
// position with a shift-based IIR filter.
// Optional feature: define CENTROID_TRACK_DROP_CNT_EN to add drop_count_out,
// a saturating count of valid_in pulses dropped while busy.
module centroid_track_smoother #(
  parameter int SMOOTH_SHIFT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in [3:0],
  input  logic [9:0]  y_in [3:0],
  input  logic        valid_in,
  input  logic [1:0]  num_players,
  output logic [10:0] x_out [3:0],
  output logic [9:0]  y_out [3:0],
  output logic        valid_out,
`ifdef CENTROID_TRACK_DROP_CNT_EN
  output logic [15:0] drop_count_out,
`endif
  output logic        busy_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_r;
  logic [10:0] lx_r [3:0];
  logic [9:0]  ly_r [3:0];
  logic [1:0]  lnp_r;
  logic [1:0]  prev_np_r;
  logic        first_frame_r;
  logic [3:0]  used_r;
  logic [1:0]  t_r;
  logic [1:0]  c_r;
  logic [1:0]  best_c_r;
  logic [11:0] best_dist_r;

  logic [10:0]        dx_s;
  logic [9:0]         dy_s;
  logic [11:0]        dist_s;
  logic               elig_s;
  logic [1:0]         win_s;
  logic signed [12:0] diff_x_s;
  logic signed [11:0] diff_y_s;
  logic [10:0]        nx_s;
  logic [9:0]         ny_s;

  function automatic logic [10:0] absdiff11(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] absdiff10(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Candidate distance/eligibility for the scan and the filtered value for the commit.
  always_comb begin
    dx_s     = absdiff11(lx_r[c_r], x_out[t_r]);
    dy_s     = absdiff10(ly_r[c_r], y_out[t_r]);
    dist_s   = {1'b0, dx_s} + {2'b00, dy_s};
    elig_s   = (c_r <= lnp_r) && !used_r[c_r];
    win_s    = first_frame_r ? t_r : best_c_r;
    diff_x_s = $signed({2'b00, lx_r[win_s]}) - $signed({2'b00, x_out[t_r]});
    diff_y_s = $signed({2'b00, ly_r[win_s]}) - $signed({2'b00, y_out[t_r]});
    // Smoothed value lies between old and new, so truncation back to the
    // coordinate width is lossless.
    nx_s     = first_frame_r ? lx_r[win_s]
             : 11'($signed({2'b00, x_out[t_r]}) + (diff_x_s >>> SMOOTH_SHIFT));
    ny_s     = first_frame_r ? ly_r[win_s]
             : 10'($signed({2'b00, y_out[t_r]}) + (diff_y_s >>> SMOOTH_SHIFT));
  end

  // Frame FSM: latch, scan candidates per track, commit, signal completion.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      valid_out     <= 1'b0;
      busy_out      <= 1'b0;
      first_frame_r <= 1'b1;
      used_r        <= 4'b0000;
      lnp_r         <= 2'd0;
      prev_np_r     <= 2'd0;
      t_r           <= 2'd0;
      c_r           <= 2'd0;
      best_c_r      <= 2'd0;
      best_dist_r   <= 12'hFFF;
      for (int i = 0; i < 4; i++) begin
        x_out[i] <= 11'd0;
        y_out[i] <= 10'd0;
        lx_r[i]  <= 11'd0;
        ly_r[i]  <= 10'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          valid_out <= 1'b0;
          if (valid_in) begin
            for (int i = 0; i < 4; i++) begin
              lx_r[i] <= x_in[i];
              ly_r[i] <= y_in[i];
            end
            lnp_r       <= num_players;
            prev_np_r   <= num_players;
            if (num_players != prev_np_r) begin
              first_frame_r <= 1'b1;
            end
            used_r      <= 4'b0000;
            t_r         <= 2'd0;
            c_r         <= 2'd0;
            best_c_r    <= 2'd0;
            best_dist_r <= 12'hFFF;
            busy_out    <= 1'b1;
            state_r     <= SCAN;
          end
        end
        SCAN: begin
          // Max real distance is 3070, so the 0xFFF seed always loses to the
          // first eligible candidate; strict compare keeps the lower index on ties.
          if (elig_s && (dist_s < best_dist_r)) begin
            best_dist_r <= dist_s;
            best_c_r    <= c_r;
          end
          c_r <= c_r + 2'd1;
          if (c_r == 2'd3) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          x_out[t_r]    <= nx_s;
          y_out[t_r]    <= ny_s;
          used_r[win_s] <= 1'b1;
          if (first_frame_r) begin
            for (int i = 0; i < 4; i++) begin
              if (2'(i) > lnp_r) begin
                x_out[i] <= 11'd0;
                y_out[i] <= 10'd0;
              end
            end
          end
          if (t_r == lnp_r) begin
            valid_out <= 1'b1;
            state_r   <= DONE;
          end else begin
            t_r         <= t_r + 2'd1;
            c_r         <= 2'd0;
            best_c_r    <= 2'd0;
            best_dist_r <= 12'hFFF;
            state_r     <= SCAN;
          end
        end
        DONE: begin
          valid_out     <= 1'b0;
          busy_out      <= 1'b0;
          first_frame_r <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef CENTROID_TRACK_DROP_CNT_EN
  // Count frames dropped because a previous frame was still in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      drop_count_out <= 16'd0;
    end else if (valid_in && busy_out && (drop_count_out != 16'hFFFF)) begin
      drop_count_out <= drop_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_centroid_track_smoother.sv
// Scoreboard bench for centroid_track_smoother: two instances (SMOOTH_SHIFT
// 1 and 0) share stimulus; a reference model predicts each frame result.
module tb_centroid_track_smoother;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x_in [3:0];
  logic [9:0]  y_in [3:0];
  logic        valid_in = 1'b0;
  logic [1:0]  np_in = 2'd0;
  logic [10:0] x_o1 [3:0];
  logic [9:0]  y_o1 [3:0];
  logic [10:0] x_o0 [3:0];
  logic [9:0]  y_o0 [3:0];
  logic        v1, v0, b1, b0;
`ifdef CENTROID_TRACK_DROP_CNT_EN
  logic [15:0] drop1, drop0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  centroid_track_smoother #(.SMOOTH_SHIFT(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
    .num_players(np_in), .x_out(x_o1), .y_out(y_o1), .valid_out(v1),
`ifdef CENTROID_TRACK_DROP_CNT_EN
    .drop_count_out(drop1),
`endif
    .busy_out(b1));

  centroid_track_smoother #(.SMOOTH_SHIFT(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
    .num_players(np_in), .x_out(x_o0), .y_out(y_o0), .valid_out(v0),
`ifdef CENTROID_TRACK_DROP_CNT_EN
    .drop_count_out(drop0),
`endif
    .busy_out(b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    logic [3:0][10:0] x1;
    logic [3:0][9:0]  y1;
    logic [3:0][10:0] x0;
    logic [3:0][9:0]  y0;
  } exp_t;
  exp_t q[$];

  // Reference model state: [0] = shift 1, [1] = shift 0
  int mx[2][4];
  int my[2][4];
  int mprev;
  bit mfirst;
  int sx[4];
  int sy[4];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int t = 0; t < 4; t++) begin
        mx[s][t] = 0;
        my[s][t] = 0;
      end
    mprev = 0;
    mfirst = 1;
  endtask

  // Greedy nearest-first matching followed by old + floor((new-old)/2^shift).
  task automatic model_frame(input int np);
    int n;
    n = np + 1;
    if (np != mprev) mfirst = 1;
    mprev = np;
    for (int s = 0; s < 2; s++) begin
      int sh;
      bit used[4];
      sh = (s == 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) used[i] = 0;
      for (int t = 0; t < 4; t++) begin
        if (t >= n) begin
          if (mfirst) begin
            mx[s][t] = 0;
            my[s][t] = 0;
          end
        end else if (mfirst) begin
          mx[s][t] = sx[t];
          my[s][t] = sy[t];
        end else begin
          int best;
          int bd;
          best = -1;
          bd = 0;
          for (int c = 0; c < n; c++) begin
            int d;
            if (!used[c]) begin
              d = iabs(sx[c] - mx[s][t]) + iabs(sy[c] - my[s][t]);
              if (best < 0 || d < bd) begin
                best = c;
                bd = d;
              end
            end
          end
          used[best] = 1;
          mx[s][t] = mx[s][t] + ((sx[best] - mx[s][t]) >>> sh);
          my[s][t] = my[s][t] + ((sy[best] - my[s][t]) >>> sh);
        end
      end
    end
    mfirst = 0;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one valid_in pulse; when expected, predict the result and queue it.
  task automatic send(input int np, input bit expect_out);
    int k;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      x_in[i] = 11'(sx[i]);
      y_in[i] = 10'(sy[i]);
    end
    np_in = 2'(np);
    valid_in = 1'b1;
    k = cyc;
    @(negedge clk);
    valid_in = 1'b0;
    if (expect_out) begin
      exp_t e;
      model_frame(np);
      e.cyc = k + 5 * (np + 1) + 1;
      for (int i = 0; i < 4; i++) begin
        e.x1[i] = 11'(mx[0][i]);
        e.y1[i] = 10'(my[0][i]);
        e.x0[i] = 11'(mx[1][i]);
        e.y0[i] = 10'(my[1][i]);
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk("frame_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_c(input int i, input int x, input int y);
    sx[i] = x;
    sy[i] = y;
  endtask

  // Monitor: pop expectation on every valid_out and compare both instances.
  initial begin
    forever begin
      @(negedge clk);
      if (v1 || v0) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_out", 1, 0);
        end else begin
          exp_t e;
          logic [3:0][10:0] ax1, ax0;
          logic [3:0][9:0]  ay1, ay0;
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            ax1[i] = x_o1[i];
            ay1[i] = y_o1[i];
            ax0[i] = x_o0[i];
            ay0[i] = y_o0[i];
          end
          chk("valid_both", int'({v1, v0}), 3);
          chk("latency_cycle", cyc, e.cyc);
          checks++;
          if (ax1 !== e.x1 || ay1 !== e.y1) begin
            errors++;
            $display("FAIL out_shift1: got x=%h y=%h expected x=%h y=%h", ax1, ay1, e.x1, e.y1);
          end
          checks++;
          if (ax0 !== e.x0 || ay0 !== e.y0) begin
            errors++;
            $display("FAIL out_shift0: got x=%h y=%h expected x=%h y=%h", ax0, ay0, e.x0, e.y0);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      x_in[i] = 11'd0;
      y_in[i] = 10'd0;
      sx[i] = 0;
      sy[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Reset state
    chk("reset_valid", int'(v1), 0);
    chk("reset_busy", int'(b1), 0);
    chk("reset_x0", int'(x_o1[0]), 0);
    chk("reset_y3", int'(y_o1[3]), 0);

    // First frame: raw copy
    set_c(0, 100, 50); set_c(1, 600, 400); set_c(2, 7, 7); set_c(3, 9, 9);
    send(1, 1'b1);
    wait_empty();
    // Swapped inputs: matching restores order, then smoothing
    set_c(0, 604, 404); set_c(1, 102, 52);
    send(1, 1'b1);
    wait_empty();
    // Negative steps (floor rounding)
    set_c(0, 98, 48); set_c(1, 599, 399);
    send(1, 1'b1);
    wait_empty();
    // Tie: re-init through num_players change, then equal distances
    send(0, 1'b1);
    wait_empty();
    set_c(0, 100, 100); set_c(1, 300, 300);
    send(1, 1'b1);
    wait_empty();
    set_c(0, 110, 100); set_c(1, 100, 110);
    send(1, 1'b1);
    wait_empty();
    chk("tie_track0_x", int'(x_o0[0]), 110);
    chk("tie_track1_y", int'(y_o0[1]), 110);

    // Drop: second pulse at cycle 3 of an N=4 frame is ignored
    for (int i = 0; i < 4; i++) set_c(i, $urandom_range(0, 2047), $urandom_range(0, 1023));
    send(3, 1'b1);
    @(negedge clk);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_empty();
`ifdef CENTROID_TRACK_DROP_CNT_EN
    chk("drop_count", int'(drop1), 1);
`endif

    // Randomized frames, num_players changes occasionally
    begin
      int np;
      np = 3;
      for (int f = 0; f < 24; f++) begin
        if ($urandom_range(0, 3) == 0) np = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) set_c(i, $urandom_range(0, 2047), $urandom_range(0, 1023));
        send(np, 1'b1);
        wait_empty();
      end
    end

    // Abort: reset at cycle 5 of an N=4 frame
    begin
      int k;
      int seen;
      for (int i = 0; i < 4; i++) set_c(i, $urandom_range(0, 2047), $urandom_range(0, 1023));
      k = cyc + 1;
      send(3, 1'b0);
      while (cyc < k + 5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("abort_x1", int'(x_o1[1]), 0);
      chk("abort_y2", int'(y_o0[2]), 0);
      chk("abort_busy", int'(b1), 0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (v1 || v0) seen++;
      end
      chk("abort_no_valid", seen, 0);
    end
    // After abort: first frame raw copy, identity order
    for (int i = 0; i < 4; i++) set_c(i, 2000 - 300 * i, 50 + 200 * i);
    send(3, 1'b1);
    wait_empty();
    // num_players 3 -> 1 forces re-init; tracks 2/3 zeroed
    set_c(0, 1500, 900); set_c(1, 10, 20);
    send(1, 1'b1);
    wait_empty();
    chk("reinit_x2", int'(x_o1[2]), 0);
    chk("reinit_y3", int'(y_o1[3]), 0);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
